dram_phase_sequencer: RTL

//  Top-level scheduler for the single-port image DRAM. Sequences the three job phases:
//   - UART-Rx image load into DRAM.
//   - Processor down-sampling run, with the processor owning the DRAM.
//   - UART-Tx dump of the result region.

---
 rtl/dram_phase_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dram_phase_sequencer.sv
// Job scheduler for the single-port image DRAM: UART-Rx load, processor run, UART-Tx dump.
// Owns the DRAM bus outside the processor phase and paces result bytes to the transmitter.
module dram_phase_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter int                IMG_BYTES = 65536,
    parameter logic [ADDR_W-1:0] OUT_BASE  = '0,
    parameter int                OUT_BYTES = 16384
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [ADDR_W-1:0] proc_address,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic              proc_write,
    input  logic              proc_done,
    output logic              enable_processor,
    output logic [ADDR_W-1:0] dram_address,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [2:0]        phase,
    output logic              done
);

    // One extra bit so a full 2^ADDR_W transfer count does not wrap to zero.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] IMG_N = CNT_W'(IMG_BYTES);
    localparam logic [CNT_W-1:0] OUT_N = CNT_W'(OUT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX      = 3'd1,
        S_PROC    = 3'd2,
        S_TX_RD   = 3'd3,
        S_TX_CAP  = 3'd4,
        S_TX_SEND = 3'd5,
        S_TX_BUSY = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              enable_q, enable_d;

    // NOTE: state uses non-blocking assignments only; all next-state logic lives in always_comb.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            enable_q   <= enable_d;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        rx_cnt_d   = rx_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        enable_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RX;
                    rx_cnt_d = '0;
                    tx_cnt_d = '0;
                end
            end
            S_RX: begin
                // Leave only once the final byte's write cycle is on the bus.
                if (rx_cnt_q == IMG_N) begin
                    state_d = S_PROC;
                end else if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = rx_cnt_q[ADDR_W-1:0];
                    wr_data_d = rx_data;
                    rx_cnt_d  = rx_cnt_q + CNT_W'(1);
                end
            end
            S_PROC: begin
                if (proc_done) state_d = S_TX_RD;
                else           enable_d = 1'b1;
            end
            S_TX_RD: state_d = S_TX_CAP;
            S_TX_CAP: begin
                tx_data_d = dram_rdata;
                state_d   = S_TX_SEND;
            end
            S_TX_SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = S_TX_BUSY;
                end
            end
            S_TX_BUSY: begin
                // tx_busy lags tx_start by a cycle, so the pulse cycle itself is ignored.
                if (!tx_start_q && !tx_busy) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    state_d  = (tx_cnt_q + CNT_W'(1) == OUT_N) ? S_DONE : S_TX_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The processor drives the DRAM directly while it owns it; otherwise the sequencer does.
    always_comb begin
        dram_address = wr_addr_q;
        dram_wdata   = wr_data_q;
        dram_we      = wr_en_q;
        if (state_q == S_PROC) begin
            dram_address = proc_address;
            dram_wdata   = proc_wdata;
            dram_we      = proc_write;
        end else if (state_q == S_TX_RD) begin
            dram_address = OUT_BASE + tx_cnt_q[ADDR_W-1:0];
        end
    end

    assign enable_processor = enable_q;
    assign tx_start         = tx_start_q;
    assign tx_data          = tx_data_q;
    assign phase            = state_q;
    assign done             = (state_q == S_DONE);

endmodule
